// File: rtl/thread_cmd_queue_if.sv
// thread_cmd_queue_if: bundles the CPU request, manager issue/result and completion signals of thread_cmd_queue.
// Latency: none (wires only). Backpressure: req_ready is driven by the queue; the manager side has none.
// Modports: slave = the queue; master = CPU cores + threads manager. Uses `DATA_SIZE/`ADDR_SIZE.
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef THREAD_CMD_RUN
`define THREAD_CMD_RUN 4'h1
`endif
`ifndef THREAD_CMD_STOP
`define THREAD_CMD_STOP 4'h2
`endif

interface thread_cmd_queue_if #(
    parameter int DEPTH = 4
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    // CPU request side
    logic                   req_valid;
    logic [3:0]             req_cmd;
    logic [`DATA_SIZE-1:0]  req_data;
    logic [`ADDR_SIZE-1:0]  req_addr;
    logic                   req_ready;

    // threads manager command port
    logic                   tm_strobe;
    logic [3:0]             tm_cmd;
    logic [`DATA_SIZE-1:0]  tm_data;
    logic [`ADDR_SIZE-1:0]  tm_addr;
    logic                   tm_done;
    logic [1:0]             tm_rslt;

    // completion report and occupancy
    logic                   done_valid;
    logic                   done_ok;
    logic [3:0]             done_cmd;
    logic [LVL_W-1:0]       level;

    modport slave (
        input  req_valid, req_cmd, req_data, req_addr, tm_done, tm_rslt,
        output req_ready, tm_strobe, tm_cmd, tm_data, tm_addr,
               done_valid, done_ok, done_cmd, level
    );

    modport master (
        output req_valid, req_cmd, req_data, req_addr, tm_done, tm_rslt,
        input  req_ready, tm_strobe, tm_cmd, tm_data, tm_addr,
               done_valid, done_ok, done_cmd, level
    );
endinterface

// File: rtl/thread_cmd_queue.sv
// thread_cmd_queue: FIFO of CPU thread commands issued one at a time to the threads manager, with retry and outcome report.
// Latency: enqueue at N -> tm_strobe at N+2; tm_done at N+2+k -> done_valid at N+3+k; each retry adds BACKOFF+1 cycles.
// Backpressure: req_ready drops only when the FIFO holds DEPTH entries; the manager is never stalled, only retried.
// Ports: clk, rst (async, active-high) and bus (thread_cmd_queue_if.slave: req_*, tm_*, done_*, level).
// Build option: define THRD_Q_RETRY_EN to enable the BACKOFF/retry path; otherwise any rejection fails at once.
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef THREAD_CMD_RUN
`define THREAD_CMD_RUN 4'h1
`endif
`ifndef THREAD_CMD_STOP
`define THREAD_CMD_STOP 4'h2
`endif

module thread_cmd_queue #(
    parameter int DEPTH     = 4,
    parameter int MAX_RETRY = 3,
    parameter int BACKOFF   = 4,
    parameter int WAIT_MAX  = 15
) (
    input  logic               clk,
    input  logic               rst,
    thread_cmd_queue_if.slave  bus
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    // one timer serves both the result wait and the backoff count
    localparam int TMR_MAX = (WAIT_MAX > BACKOFF) ? WAIT_MAX : BACKOFF;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
`ifdef THRD_Q_RETRY_EN
    localparam int RTY_W   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
`ifdef THRD_Q_RETRY_EN
        , S_BACKOFF
`endif
    } state_t;

    state_t                 state;
    logic [TMR_W-1:0]       tmr;
`ifdef THRD_Q_RETRY_EN
    logic [RTY_W-1:0]       retry_cnt;
`endif

    // FIFO storage and pointers
    logic [3:0]             q_cmd  [DEPTH];
    logic [`DATA_SIZE-1:0]  q_data [DEPTH];
    logic [`ADDR_SIZE-1:0]  q_addr [DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [LVL_W-1:0]       level_q;
    logic                   push;
    logic                   pop;

    function automatic logic cmd_known(input logic [3:0] c);
        return (c == `THREAD_CMD_RUN) || (c == `THREAD_CMD_STOP);
    endfunction

    assign bus.req_ready = (level_q != LVL_W'(DEPTH));
    assign bus.level     = level_q;
    assign push          = bus.req_valid && bus.req_ready;
    // The cycle that carries done_valid is spent idle, so the next command
    // strobes at least two cycles after the previous completion.
    assign pop           = (state == S_IDLE) && (level_q != '0) && !bus.done_valid;

    always_ff @(posedge clk) begin
        if (push) begin
            q_cmd[wr_ptr]  <= bus.req_cmd;
            q_data[wr_ptr] <= bus.req_data;
            q_addr[wr_ptr] <= bus.req_addr;
        end
    end

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            tmr            <= '0;
`ifdef THRD_Q_RETRY_EN
            retry_cnt      <= '0;
`endif
            bus.tm_strobe  <= 1'b0;
            bus.tm_cmd     <= '0;
            bus.tm_data    <= '0;
            bus.tm_addr    <= '0;
            bus.done_valid <= 1'b0;
            bus.done_ok    <= 1'b0;
            bus.done_cmd   <= '0;
        end else begin
            bus.tm_strobe  <= 1'b0;
            bus.done_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        bus.tm_cmd    <= q_cmd[rd_ptr];
                        bus.tm_data   <= q_data[rd_ptr];
                        bus.tm_addr   <= q_addr[rd_ptr];
                        // unknown codes never reach the manager
                        bus.tm_strobe <= cmd_known(q_cmd[rd_ptr]);
`ifdef THRD_Q_RETRY_EN
                        retry_cnt     <= '0;
`endif
                        state         <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    tmr <= '0;
                    if (cmd_known(bus.tm_cmd)) begin
                        state <= S_WAIT;
                    end else begin
                        bus.done_valid <= 1'b1;
                        bus.done_ok    <= 1'b0;
                        bus.done_cmd   <= bus.tm_cmd;
                        state          <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (bus.tm_done) begin
                        if (bus.tm_rslt == 2'd1) begin
                            bus.done_valid <= 1'b1;
                            bus.done_ok    <= 1'b1;
                            bus.done_cmd   <= bus.tm_cmd;
                            state          <= S_IDLE;
`ifdef THRD_Q_RETRY_EN
                        end else if (retry_cnt < RTY_W'(MAX_RETRY)) begin
                            tmr   <= '0;
                            state <= S_BACKOFF;
`endif
                        end else begin
                            // rslt 0, 2 and 3 all count as rejection
                            bus.done_valid <= 1'b1;
                            bus.done_ok    <= 1'b0;
                            bus.done_cmd   <= bus.tm_cmd;
                            state          <= S_IDLE;
                        end
                    end else if (tmr == TMR_W'(WAIT_MAX - 1)) begin
                        // manager silent too long: fail without retry
                        bus.done_valid <= 1'b1;
                        bus.done_ok    <= 1'b0;
                        bus.done_cmd   <= bus.tm_cmd;
                        state          <= S_IDLE;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
`ifdef THRD_Q_RETRY_EN
                S_BACKOFF: begin
                    if (tmr == TMR_W'(BACKOFF - 1)) begin
                        retry_cnt     <= retry_cnt + 1'b1;
                        bus.tm_strobe <= 1'b1;
                        state         <= S_ISSUE;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_thread_cmd_queue.sv
// tb_thread_cmd_queue: directed scoreboard bench for thread_cmd_queue with a scripted threads-manager model.
// Latency: stimulus pushes expected strobes/completions; a negedge monitor pops and compares them.
// Backpressure: FIFO-full behaviour is exercised by stalling the manager model.
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef THREAD_CMD_RUN
`define THREAD_CMD_RUN 4'h1
`endif
`ifndef THREAD_CMD_STOP
`define THREAD_CMD_STOP 4'h2
`endif

module tb_thread_cmd_queue;
    localparam int DEPTH     = 4;
    localparam int MAX_RETRY = 3;
    localparam int BACKOFF   = 4;
    localparam int WAIT_MAX  = 15;
    localparam logic [3:0] RUN  = `THREAD_CMD_RUN;
    localparam logic [3:0] STOP = `THREAD_CMD_STOP;
    localparam logic [3:0] BAD  = 4'hF;

    typedef struct {
        logic [3:0]            cmd;
        logic [`DATA_SIZE-1:0] data;
        logic [`ADDR_SIZE-1:0] addr;
    } strb_t;
    typedef struct {
        logic       ok;
        logic [3:0] cmd;
    } done_t;
    typedef struct {
        int         delay;
        logic [1:0] rslt;
        bit         silent;
    } mgr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    bit   gap_chk = 1'b0;

    strb_t exp_s[$];
    done_t exp_d[$];
    mgr_t  mgr_q[$];
    int    strobe_cycs[$];
    int    done_cycs[$];

    thread_cmd_queue_if #(.DEPTH(DEPTH)) b();

    thread_cmd_queue #(
        .DEPTH(DEPTH), .MAX_RETRY(MAX_RETRY), .BACKOFF(BACKOFF), .WAIT_MAX(WAIT_MAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(b.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int sc(input int i);
        return (i < strobe_cycs.size()) ? strobe_cycs[i] : -1000;
    endfunction
    function automatic int dc(input int i);
        return (i < done_cycs.size()) ? done_cycs[i] : -1000;
    endfunction

    task automatic exp_strobe(input logic [3:0] c, input logic [`DATA_SIZE-1:0] d, input logic [`ADDR_SIZE-1:0] a);
        strb_t e;
        e.cmd = c; e.data = d; e.addr = a;
        exp_s.push_back(e);
    endtask
    task automatic exp_done(input logic ok, input logic [3:0] c);
        done_t e;
        e.ok = ok; e.cmd = c;
        exp_d.push_back(e);
    endtask
    task automatic mgr(input int delay, input logic [1:0] rslt, input bit silent);
        mgr_t m;
        m.delay = delay; m.rslt = rslt; m.silent = silent;
        mgr_q.push_back(m);
    endtask

    // called at posedge+1; request is held for exactly one cycle
    task automatic enq(input logic [3:0] c, input logic [`DATA_SIZE-1:0] d,
                       input logic [`ADDR_SIZE-1:0] a, output int n);
        b.req_valid = 1'b1; b.req_cmd = c; b.req_data = d; b.req_addr = a;
        n = cyc;
        @(posedge clk); #1;
        b.req_valid = 1'b0;
    endtask

    task automatic drain(input int budget, input string name);
        int k = 0;
        while ((exp_s.size() != 0 || exp_d.size() != 0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(name, exp_s.size() + exp_d.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic clear_hist();
        strobe_cycs.delete();
        done_cycs.delete();
    endtask

    // threads manager model: answers each strobe from the script
    initial begin : manager
        mgr_t m;
        b.tm_done = 1'b0;
        b.tm_rslt = 2'd0;
        forever begin
            @(negedge clk);
            if (!rst && b.tm_strobe && mgr_q.size() != 0) begin
                m = mgr_q.pop_front();
                if (!m.silent) begin
                    repeat (m.delay) @(posedge clk);
                    #1;
                    b.tm_done = 1'b1;
                    b.tm_rslt = m.rslt;
                    @(posedge clk); #1;
                    b.tm_done = 1'b0;
                    b.tm_rslt = 2'd0;
                end
            end
        end
    end

    // monitor: pops the scoreboard whenever the DUT presents a strobe or a completion
    always @(negedge clk) begin
        if (!rst) begin
            if (b.tm_strobe) begin
                if (gap_chk && done_cycs.size() != 0)
                    chk("strobe_gap_after_done", ((cyc - done_cycs[$]) >= 2) ? 1 : 0, 1);
                strobe_cycs.push_back(cyc);
                if (exp_s.size() == 0) begin
                    chk("unexpected_strobe_cmd", b.tm_cmd, 64'hdead);
                end else begin
                    strb_t e;
                    e = exp_s.pop_front();
                    chk("strobe_cmd", b.tm_cmd, e.cmd);
                    chk("strobe_data", b.tm_data, e.data);
                    chk("strobe_addr", b.tm_addr, e.addr);
                end
            end
            if (b.done_valid) begin
                done_cycs.push_back(cyc);
                if (exp_d.size() == 0) begin
                    chk("unexpected_done_cmd", b.done_cmd, 64'hdead);
                end else begin
                    done_t e;
                    e = exp_d.pop_front();
                    chk("done_ok", b.done_ok, e.ok);
                    chk("done_cmd", b.done_cmd, e.cmd);
                end
            end
        end
    end

    initial begin : stim
        int n;
        int k;
        b.req_valid = 1'b0;
        b.req_cmd   = '0;
        b.req_data  = '0;
        b.req_addr  = '0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", b.req_ready, 1);
        chk("rst_level", b.level, 0);
        chk("rst_tm_strobe", b.tm_strobe, 0);
        chk("rst_tm_cmd", b.tm_cmd, 0);
        chk("rst_done_valid", b.done_valid, 0);
        chk("rst_done_cmd", b.done_cmd, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready", b.req_ready, 1);
        @(posedge clk); #1;

        // single RUN accepted 2 cycles after the strobe
        clear_hist();
        mgr(2, 2'd1, 1'b0);
        exp_strobe(RUN, 'h5, 'h100);
        exp_done(1'b1, RUN);
        enq(RUN, 'h5, 'h100, n);
        drain(100, "t1_drain");
        chk("t1_strobe_cycle", sc(0), n + 2);
        chk("t1_done_cycle", dc(0), n + 5);
        chk("t1_level", b.level, 0);

        // fill while the manager stalls; sixth request must bounce
        clear_hist();
        gap_chk = 1'b1;
        for (int i = 0; i < 5; i++) begin
            mgr(10, 2'd1, 1'b0);
            exp_strobe((i % 2) ? STOP : RUN, 'h20 + i, 'h200 + i);
            exp_done(1'b1, (i % 2) ? STOP : RUN);
        end
        for (int i = 0; i < 6; i++) begin
            b.req_valid = 1'b1;
            b.req_cmd   = (i % 2) ? STOP : RUN;
            b.req_data  = 'h20 + i;
            b.req_addr  = 'h200 + i;
            @(negedge clk);
            chk((i == 5) ? "t2_ready_full" : "t2_ready", b.req_ready, (i < 5) ? 1 : 0);
            if (i == 5) chk("t2_level_full", b.level, DEPTH);
            @(posedge clk); #1;
        end
        b.req_valid = 1'b0;
        @(negedge clk);
        chk("t2_level_after_bounce", b.level, DEPTH);
        @(posedge clk); #1;
        drain(400, "t2_drain");
        gap_chk = 1'b0;
        chk("t2_done_count", done_cycs.size(), 5);
        chk("t2_level_end", b.level, 0);

        // STOP rejected twice then accepted
        clear_hist();
        mgr(2, 2'd0, 1'b0);
        mgr(2, 2'd0, 1'b0);
        mgr(2, 2'd1, 1'b0);
`ifdef THRD_Q_RETRY_EN
        repeat (3) exp_strobe(STOP, 'h33, 'h300);
        exp_done(1'b1, STOP);
`else
        exp_strobe(STOP, 'h33, 'h300);
        exp_done(1'b0, STOP);
`endif
        enq(STOP, 'h33, 'h300, n);
        drain(200, "t3_drain");
        repeat (10) @(posedge clk);
        #1;
`ifdef THRD_Q_RETRY_EN
        chk("t3_strobe_count", strobe_cycs.size(), 3);
        chk("t3_retry1_spacing", sc(1) - sc(0), 2 + BACKOFF + 1);
        chk("t3_retry2_spacing", sc(2) - sc(1), 2 + BACKOFF + 1);
        chk("t3_done_cycle", dc(0), sc(2) + 3);
`else
        chk("t3_strobe_count", strobe_cycs.size(), 1);
        chk("t3_done_cycle", dc(0), sc(0) + 3);
`endif
        chk("t3_done_count", done_cycs.size(), 1);
        mgr_q.delete();

        // always reject (codes 2, 3, 0 all reject)
        clear_hist();
        mgr(1, 2'd2, 1'b0);
        mgr(1, 2'd3, 1'b0);
        mgr(1, 2'd0, 1'b0);
        mgr(1, 2'd0, 1'b0);
`ifdef THRD_Q_RETRY_EN
        repeat (MAX_RETRY + 1) exp_strobe(RUN, 'h44, 'h400);
`else
        exp_strobe(RUN, 'h44, 'h400);
`endif
        exp_done(1'b0, RUN);
        enq(RUN, 'h44, 'h400, n);
        drain(200, "t4_drain");
        repeat (10) @(posedge clk);
        #1;
`ifdef THRD_Q_RETRY_EN
        chk("t4_strobe_count", strobe_cycs.size(), MAX_RETRY + 1);
        chk("t4_spacing", sc(3) - sc(2), 1 + BACKOFF + 1);
        chk("t4_done_cycle", dc(0), sc(3) + 2);
`else
        chk("t4_strobe_count", strobe_cycs.size(), 1);
        chk("t4_done_cycle", dc(0), sc(0) + 2);
`endif
        mgr_q.delete();

        // unknown code completes without a strobe
        clear_hist();
        exp_done(1'b0, BAD);
        enq(BAD, 'h55, 'h500, n);
        drain(50, "t5_drain");
        chk("t5_strobe_count", strobe_cycs.size(), 0);
        chk("t5_done_cycle", dc(0), n + 3);

        // silent manager: timeout, no retry
        clear_hist();
        mgr(0, 2'd0, 1'b1);
        exp_strobe(RUN, 'h66, 'h600);
        exp_done(1'b0, RUN);
        enq(RUN, 'h66, 'h600, n);
        drain(100, "t6_drain");
        k = dc(0) - sc(0);
        chk("t6_timeout_window", (k >= WAIT_MAX && k <= WAIT_MAX + 2) ? 1 : 0, 1);
        repeat (20) @(posedge clk);
        #1;
        chk("t6_strobe_count", strobe_cycs.size(), 1);

        // reset while waiting with one command still queued
        clear_hist();
        mgr(0, 2'd0, 1'b1);
        exp_strobe(STOP, 'h77, 'h700);
        enq(STOP, 'h77, 'h700, n);
        enq(RUN, 'h88, 'h800, n);
        k = 0;
        while (strobe_cycs.size() == 0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("t7_strobe_seen", strobe_cycs.size(), 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t7_level_before_rst", b.level, 1);
        chk("t7_tm_cmd_before_rst", b.tm_cmd, STOP);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("t7_rst_tm_strobe", b.tm_strobe, 0);
        chk("t7_rst_tm_cmd", b.tm_cmd, 0);
        chk("t7_rst_tm_data", b.tm_data, 0);
        chk("t7_rst_tm_addr", b.tm_addr, 0);
        chk("t7_rst_done_valid", b.done_valid, 0);
        chk("t7_rst_done_ok", b.done_ok, 0);
        chk("t7_rst_done_cmd", b.done_cmd, 0);
        chk("t7_rst_level", b.level, 0);
        chk("t7_rst_req_ready", b.req_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("t7_no_strobe_after_rst", strobe_cycs.size(), 1);
        chk("t7_no_done_after_rst", done_cycs.size(), 0);
        chk("t7_level_end", b.level, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // global watchdog so the run always ends
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation still running at cycle %0d, want finished", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
